// File: rtl/prog_load_pkg.sv
// prog_load_pkg: shared types and defaults for the program-load controller.
//   state_t       : controller mode (RUN, LOAD, DONE)
//   lane_idx_t    : byte-lane index inside a 32-bit little-endian word
//   DEF_*         : default timing constants
//   csum_step     : checksum accumulation step
package prog_load_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] lane_idx_t;

    localparam int DEF_TIMEOUT_CYC = 10_000_000;
    localparam int DEF_RST_HOLD    = 4;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/prog_load_ctrl_if.sv
// prog_load_ctrl_if: UART byte stream and memory write port bundle.
//   rx_valid/rx_data/rx_err : byte strobe, byte, framing-error strobe (toward the controller)
//   imem_we/dmem_we         : write strobes for instruction / data memory
//   mem_addr/mem_wdata      : word address in the selected memory and word to write
// Modports: master = UART/memory side (drives rx_*), slave = controller.
interface prog_load_ctrl_if #(
    parameter int ADDR_W = 14
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_err;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output rx_valid, rx_data, rx_err,
        input  imem_we, dmem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data, rx_err,
        output imem_we, dmem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_load_ctrl_word_assembler.sv
// word_assembler: packs accepted bytes into a 32-bit little-endian word.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart at lane 0 (load entry, discarded partial word)
//   accept     : byte_in is valid and belongs to the current load
//   byte_in    : incoming byte
//   byte_idx   : lane the next byte goes to
//   word_ready : high in the cycle the 4th byte is accepted
//   word       : assembled word, valid together with word_ready
module word_assembler
    import prog_load_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output lane_idx_t   byte_idx,
    output logic        word_ready,
    output logic [31:0] word
);

    lane_idx_t   idx_r;
    logic [23:0] lanes_r;

    // Lane index and storage for the three low lanes; lane 3 comes straight from byte_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= 2'd0;
            lanes_r <= 24'h000000;
        end else if (clr) begin
            idx_r <= 2'd0;
        end else if (accept) begin
            case (idx_r)
                2'd0:    lanes_r[7:0]   <= byte_in;
                2'd1:    lanes_r[15:8]  <= byte_in;
                2'd2:    lanes_r[23:16] <= byte_in;
                default: lanes_r        <= lanes_r;
            endcase
            idx_r <= idx_r + 2'd1;
        end
    end

    assign byte_idx   = idx_r;
    assign word_ready = accept & (idx_r == 2'd3);
    assign word       = {byte_in, lanes_r};

endmodule

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: RUN/LOAD sequencer sharing imem/dmem write ports with a UART byte stream.
//   clk, rst    : clock, synchronous active-high reset
//   start_pg    : level request; its rising edge starts a load from RUN
//   bus         : prog_load_ctrl_if.slave (UART bytes in, memory writes out)
//   cpu_rst     : CPU reset, held high during LOAD and RST_HOLD cycles after it
//   load_busy   : high in LOAD
//   load_err    : sticky error (rx framing error or timeout with a partial word)
//   word_count  : words written in the current or last load
//   checksum    : XOR of accepted bytes when PROG_CHECKSUM_EN is defined, else 0
// Optional feature macro: PROG_CHECKSUM_EN.
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int IMEM_WORDS  = 16384,
    parameter int DMEM_WORDS  = 16384,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int RST_HOLD    = DEF_RST_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_pg,
    prog_load_ctrl_if.slave    bus,
    output logic               cpu_rst,
    output logic               load_busy,
    output logic               load_err,
    output logic [ADDR_W:0]    word_count,
    output logic [7:0]         checksum
);

    // Internal count is one bit wider than word_count so the full-load total is representable.
    localparam int CNT_W  = ADDR_W + 2;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [CNT_W-1:0]  IMEM_C    = CNT_W'(IMEM_WORDS);
    localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(IMEM_WORDS + DMEM_WORDS);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_t            state_r;
    logic              start_q_r;
    logic [CNT_W-1:0]  count_r;
    logic [TO_W-1:0]   idle_r;
    logic              got_byte_r;
    logic [HOLD_W-1:0] hold_r;

    logic              rise_s;
    logic              accept_s;
    logic              timeout_s;
    logic              clr_s;
    logic              dmem_sel_s;
    logic [ADDR_W-1:0] addr_s;
    logic [CNT_W-1:0]  count_next_s;
    lane_idx_t         byte_idx_s;
    logic              word_ready_s;
    logic [31:0]       word_s;

    assign rise_s       = start_pg & ~start_q_r;
    assign accept_s     = (state_r == ST_LOAD) & bus.rx_valid;
    // Idle timer only arms after the first byte, so LOAD waits forever for a sender.
    assign timeout_s    = (state_r == ST_LOAD) & ~bus.rx_valid & got_byte_r & (idle_r == TO_LAST);
    assign clr_s        = ((state_r == ST_RUN) & rise_s) | timeout_s;
    assign count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Route the pending word to imem for the first IMEM_WORDS words, then to dmem.
    always_comb begin
        dmem_sel_s = 1'b0;
        addr_s     = ADDR_W'(count_r);
        if (count_r >= IMEM_C) begin
            dmem_sel_s = 1'b1;
            addr_s     = ADDR_W'(count_r - IMEM_C);
        end else begin
            dmem_sel_s = 1'b0;
            addr_s     = ADDR_W'(count_r);
        end
    end

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_s),
        .accept     (accept_s),
        .byte_in    (bus.rx_data),
        .byte_idx   (byte_idx_s),
        .word_ready (word_ready_s),
        .word       (word_s)
    );

    // Mode FSM with registered outputs, word counter, idle timer and reset-hold timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            start_q_r     <= 1'b0;
            count_r       <= '0;
            idle_r        <= '0;
            got_byte_r    <= 1'b0;
            hold_r        <= '0;
            cpu_rst       <= 1'b1;
            load_busy     <= 1'b0;
            load_err      <= 1'b0;
            bus.imem_we   <= 1'b0;
            bus.dmem_we   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'h0000_0000;
        end else begin
            start_q_r   <= start_pg;
            bus.imem_we <= 1'b0;
            bus.dmem_we <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    cpu_rst   <= 1'b0;
                    load_busy <= 1'b0;
                    if (rise_s) begin
                        state_r    <= ST_LOAD;
                        cpu_rst    <= 1'b1;
                        load_busy  <= 1'b1;
                        count_r    <= '0;
                        load_err   <= 1'b0;
                        idle_r     <= '0;
                        got_byte_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bus.rx_err) begin
                        load_err <= 1'b1;
                    end
                    if (accept_s) begin
                        idle_r     <= '0;
                        got_byte_r <= 1'b1;
                    end else if (got_byte_r) begin
                        idle_r <= idle_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                    if (word_ready_s) begin
                        bus.imem_we   <= ~dmem_sel_s;
                        bus.dmem_we   <= dmem_sel_s;
                        bus.mem_addr  <= addr_s;
                        bus.mem_wdata <= word_s;
                        count_r       <= count_next_s;
                        if (count_next_s == TOTAL_C) begin
                            state_r   <= ST_DONE;
                            load_busy <= 1'b0;
                            hold_r    <= '0;
                        end
                    end else if (timeout_s) begin
                        state_r   <= ST_DONE;
                        load_busy <= 1'b0;
                        hold_r    <= '0;
                        if (byte_idx_s != 2'd0) begin
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    load_busy <= 1'b0;
                    if (hold_r == HOLD_LAST) begin
                        state_r <= ST_RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        hold_r <= hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= ST_RUN;
                    cpu_rst   <= 1'b1;
                    load_busy <= 1'b0;
                end
            endcase
        end
    end

    assign word_count = count_r[ADDR_W:0];

`ifdef PROG_CHECKSUM_EN
    logic [7:0] csum_r;

    // XOR of every byte accepted in LOAD, cleared on LOAD entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_r <= 8'h00;
        end else if ((state_r == ST_RUN) && rise_s) begin
            csum_r <= 8'h00;
        end else if (accept_s) begin
            csum_r <= csum_step(csum_r, bus.rx_data);
        end
    end

    assign checksum = csum_r;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: table-driven directed bench for prog_load_ctrl
// (IMEM_WORDS=2, DMEM_WORDS=1, TIMEOUT_CYC=20, RST_HOLD=4).
module tb_prog_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_pg;
    logic        cpu_rst;
    logic        load_busy;
    logic        load_err;
    logic [14:0] word_count;
    logic [7:0]  checksum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_load_ctrl_if #(.ADDR_W(14)) bus ();

    prog_load_ctrl #(
        .ADDR_W      (14),
        .IMEM_WORDS  (2),
        .DMEM_WORDS  (1),
        .TIMEOUT_CYC (20),
        .RST_HOLD    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_pg   (start_pg),
        .bus        (bus),
        .cpu_rst    (cpu_rst),
        .load_busy  (load_busy),
        .load_err   (load_err),
        .word_count (word_count),
        .checksum   (checksum)
    );

    typedef struct {
        logic        r;
        logic        s;
        logic        rv;
        logic [7:0]  rd;
        logic        re;
        logic        ei;
        logic        ed;
        logic [13:0] ea;
        logic [31:0] ew;
        logic        ec;
        logic        eb;
        logic        ee;
        logic [14:0] wc;
        logic [7:0]  cs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [7:0] rd,
                                input logic re, input logic ei, input logic ed, input logic [13:0] ea,
                                input logic [31:0] ew, input logic ec, input logic eb, input logic ee,
                                input logic [14:0] wc, input logic [7:0] cs);
        vec_t v;
        v.r = r; v.s = s; v.rv = rv; v.rd = rd; v.re = re;
        v.ei = ei; v.ed = ed; v.ea = ea; v.ew = ew;
        v.ec = ec; v.eb = eb; v.ee = ee; v.wc = wc; v.cs = cs;
        return v;
    endfunction

    // Expected checksum depends on whether the accumulator is built.
    function automatic logic [7:0] cx(input logic [7:0] x);
`ifdef PROG_CHECKSUM_EN
        return x;
`else
        return 8'h00 & x;
`endif
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst          = v.r;
        start_pg     = v.s;
        bus.rx_valid = v.rv;
        bus.rx_data  = v.rd;
        bus.rx_err   = v.re;
        @(posedge clk);
        #1;
        chk("imem_we",    idx, 32'(bus.imem_we),   32'(v.ei));
        chk("dmem_we",    idx, 32'(bus.dmem_we),   32'(v.ed));
        chk("mem_addr",   idx, 32'(bus.mem_addr),  32'(v.ea));
        chk("mem_wdata",  idx, bus.mem_wdata,      v.ew);
        chk("cpu_rst",    idx, 32'(cpu_rst),       32'(v.ec));
        chk("load_busy",  idx, 32'(load_busy),     32'(v.eb));
        chk("load_err",   idx, 32'(load_err),      32'(v.ee));
        chk("word_count", idx, 32'(word_count),    32'(v.wc));
        chk("checksum",   idx, 32'(checksum),      32'(v.cs));
    endtask

    initial begin
        //                 r  s  rv rd     re ei dm addr  wdata         cpu bsy err wc  cs
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h00000000, 1, 0, 0, 15'd0, cx(8'h00)));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h00000000, 1, 0, 0, 15'd0, cx(8'h00)));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h00000000, 0, 0, 0, 15'd0, cx(8'h00)));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 14'd0, 32'h00000000, 1, 1, 0, 15'd0, cx(8'h00)));
        tbl.push_back(mk(0, 1, 1, 8'h78, 0, 0, 0, 14'd0, 32'h00000000, 1, 1, 0, 15'd0, cx(8'h78)));
        tbl.push_back(mk(0, 0, 1, 8'h56, 0, 0, 0, 14'd0, 32'h00000000, 1, 1, 0, 15'd0, cx(8'h2E)));
        tbl.push_back(mk(0, 0, 1, 8'h34, 0, 0, 0, 14'd0, 32'h00000000, 1, 1, 0, 15'd0, cx(8'h1A)));
        tbl.push_back(mk(0, 0, 1, 8'h12, 0, 1, 0, 14'd0, 32'h12345678, 1, 1, 0, 15'd1, cx(8'h08)));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h12345678, 1, 1, 0, 15'd1, cx(8'h08)));
        tbl.push_back(mk(0, 0, 1, 8'h11, 0, 0, 0, 14'd0, 32'h12345678, 1, 1, 0, 15'd1, cx(8'h19)));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 14'd0, 32'h12345678, 1, 1, 1, 15'd1, cx(8'h19)));
        tbl.push_back(mk(0, 0, 1, 8'h22, 0, 0, 0, 14'd0, 32'h12345678, 1, 1, 1, 15'd1, cx(8'h3B)));
        tbl.push_back(mk(0, 0, 1, 8'h33, 0, 0, 0, 14'd0, 32'h12345678, 1, 1, 1, 15'd1, cx(8'h08)));
        tbl.push_back(mk(0, 0, 1, 8'h44, 0, 1, 0, 14'd1, 32'h44332211, 1, 1, 1, 15'd2, cx(8'h4C)));
        tbl.push_back(mk(0, 0, 1, 8'hAA, 0, 0, 0, 14'd1, 32'h44332211, 1, 1, 1, 15'd2, cx(8'hE6)));
        tbl.push_back(mk(0, 0, 1, 8'hBB, 0, 0, 0, 14'd1, 32'h44332211, 1, 1, 1, 15'd2, cx(8'h5D)));
        tbl.push_back(mk(0, 0, 1, 8'hCC, 0, 0, 0, 14'd1, 32'h44332211, 1, 1, 1, 15'd2, cx(8'h91)));
        tbl.push_back(mk(0, 0, 1, 8'hDD, 0, 0, 1, 14'd0, 32'hDDCCBBAA, 1, 0, 1, 15'd3, cx(8'h4C)));
        tbl.push_back(mk(0, 0, 1, 8'hEE, 0, 0, 0, 14'd0, 32'hDDCCBBAA, 1, 0, 1, 15'd3, cx(8'h4C)));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'hDDCCBBAA, 1, 0, 1, 15'd3, cx(8'h4C)));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'hDDCCBBAA, 1, 0, 1, 15'd3, cx(8'h4C)));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'hDDCCBBAA, 0, 0, 1, 15'd3, cx(8'h4C)));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 14'd0, 32'hDDCCBBAA, 1, 1, 0, 15'd0, cx(8'h00)));
        tbl.push_back(mk(0, 0, 1, 8'h01, 0, 0, 0, 14'd0, 32'hDDCCBBAA, 1, 1, 0, 15'd0, cx(8'h01)));
        tbl.push_back(mk(0, 1, 1, 8'h02, 0, 0, 0, 14'd0, 32'hDDCCBBAA, 1, 1, 0, 15'd0, cx(8'h03)));
        tbl.push_back(mk(0, 0, 1, 8'h04, 0, 0, 0, 14'd0, 32'hDDCCBBAA, 1, 1, 0, 15'd0, cx(8'h07)));
        tbl.push_back(mk(0, 0, 1, 8'h08, 0, 1, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd1, cx(8'h0F)));
        tbl.push_back(mk(0, 0, 1, 8'h05, 0, 0, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd1, cx(8'h0A)));
        tbl.push_back(mk(0, 0, 1, 8'h06, 0, 0, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd1, cx(8'h0C)));

        foreach (tbl[i]) begin
            apply(tbl[i], i);
        end

        // Idle timeout with a partial word pending: still busy for 19 idle cycles.
        for (int k = 0; k < 19; k++) begin
            apply(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd1, cx(8'h0C)), 100 + k);
        end
        // 20th idle cycle ends the load with load_err set.
        apply(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h08040201, 1, 0, 1, 15'd1, cx(8'h0C)), 119);
        for (int k = 0; k < 3; k++) begin
            apply(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h08040201, 1, 0, 1, 15'd1, cx(8'h0C)), 120 + k);
        end
        apply(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h08040201, 0, 0, 1, 15'd1, cx(8'h0C)), 123);

        // New load waits indefinitely before the first byte.
        apply(mk(0, 1, 0, 8'h00, 0, 0, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd0, cx(8'h00)), 200);
        for (int k = 0; k < 30; k++) begin
            apply(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd0, cx(8'h00)), 201 + k);
        end

        // Reset in the cycle the 4th byte arrives: no strobe, everything back to reset values.
        apply(mk(0, 0, 1, 8'hA1, 0, 0, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd0, cx(8'hA1)), 300);
        apply(mk(0, 0, 1, 8'hB2, 0, 0, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd0, cx(8'h13)), 301);
        apply(mk(0, 0, 1, 8'hC3, 0, 0, 0, 14'd0, 32'h08040201, 1, 1, 0, 15'd0, cx(8'hD0)), 302);
        apply(mk(1, 0, 1, 8'hD4, 0, 0, 0, 14'd0, 32'h00000000, 1, 0, 0, 15'd0, cx(8'h00)), 303);
        apply(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h00000000, 0, 0, 0, 15'd0, cx(8'h00)), 304);
        // Bytes in RUN are ignored.
        apply(mk(0, 0, 1, 8'h55, 1, 0, 0, 14'd0, 32'h00000000, 0, 0, 0, 15'd0, cx(8'h00)), 305);
        apply(mk(0, 0, 0, 8'h00, 0, 0, 0, 14'd0, 32'h00000000, 0, 0, 0, 15'd0, cx(8'h00)), 306);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
